// File: rtl/approx_dot_pkg.sv
// Shared types and constants for the approximate dot-product accumulator.
// Contents: FSM state enum, operand/product widths, the S1 pipeline payload
// struct and a pure reference function for the approx_5 product.
package approx_dot_pkg;

  localparam int unsigned OPND_W = 4;
  localparam int unsigned PROD_W = 8;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Product stage payload: registered product plus beat qualifiers.
  typedef struct packed {
    logic              valid;
    logic              last;
    logic [PROD_W-1:0] prod;
  } s1_t;

  // 2x2 approximate block: drops a0&b0 and folds a1&b0 into the LSB.
  function automatic logic [2:0] approx_mul2(input logic [1:0] a, input logic [1:0] b);
    return {a[1] & b[1], (a[0] & b[1]) | (a[1] & b[0]), a[1] & b[0]};
  endfunction

  // 4x4 approximate product built from four 2x2 blocks.
  function automatic logic [PROD_W-1:0] approx_mul4(input logic [OPND_W-1:0] x,
                                                    input logic [OPND_W-1:0] y);
    return PROD_W'(approx_mul2(x[1:0], y[1:0]))
         + (PROD_W'(approx_mul2(x[1:0], y[3:2])) << 2)
         + (PROD_W'(approx_mul2(x[3:2], y[1:0])) << 2)
         + (PROD_W'(approx_mul2(x[3:2], y[3:2])) << 4);
  endfunction

endpackage

// File: rtl/approx_dot_acc_if.sv
// Operand-beat and result handshake bundle for approx_dot_acc.
// master: upstream/downstream side (drives beats and out_ready).
// slave : the accumulator (drives in_ready and the result).
interface approx_dot_acc_if #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned CNT_W = 9
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_a;
  logic [3:0]       in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/approx_5.sv
// approx_5: combinational 4x4 approximate multiplier from four 2x2 blocks.
// Ports: x_i, y_i (4-bit operands), prod_c (8-bit approximate product).
module approx_5
  import approx_dot_pkg::*;
(
  input  logic [OPND_W-1:0] x_i,
  input  logic [OPND_W-1:0] y_i,
  output logic [PROD_W-1:0] prod_c
);

  // blk[2*i+j] = block of x half i times y half j
  logic [3:0][2:0] blk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_x
    for (genvar gj = 0; gj < 2; gj++) begin : g_y
      logic [1:0] xs;
      logic [1:0] ys;
      assign xs = x_i[2*gi +: 2];
      assign ys = y_i[2*gj +: 2];
      assign blk[2*gi+gj] = {xs[1] & ys[1], (xs[0] & ys[1]) | (xs[1] & ys[0]), xs[1] & ys[0]};
    end
  end

  assign prod_c = PROD_W'(blk[0])
                + (PROD_W'(blk[1]) << 2)
                + (PROD_W'(blk[2]) << 2)
                + (PROD_W'(blk[3]) << 4);

endmodule

// File: rtl/approx_dot_acc.sv
// approx_dot_acc: streaming approximate dot-product accumulator.
// Each accepted beat is multiplied by approx_5 (S1 register), then added into
// the accumulator (S2). One result per vector, ended by in_last or MAX_LEN.
// Ports: clk, rst (sync active-high), dot_s (approx_dot_acc_if.slave).
// Build option: APPROX_DOT_SAT_EN -- saturate the accumulator on overflow
// instead of wrapping; out_ovf is reported either way.
module approx_dot_acc
  import approx_dot_pkg::*;
#(
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  approx_dot_acc_if.slave  dot_s
);

  localparam int unsigned SUM_W = ACC_W + 1;

  localparam logic [1:0] S_ACCUM = ST_ACCUM;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [1:0] S_DONE  = ST_DONE;

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);

  logic [1:0]       state_q,     state_d;
  s1_t              s1_q,        s1_d;
  logic [ACC_W-1:0] acc_q,       acc_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             ovf_q,       ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q,  in_ready_d;

  logic [PROD_W-1:0] prod_c;
  logic              accept_c;
  logic              beat_end_c;
  logic [SUM_W-1:0]  sum_c;

  approx_5 u_mul (
    .x_i    (dot_s.in_a),
    .y_i    (dot_s.in_b),
    .prod_c (prod_c)
  );

  assign accept_c   = in_ready_q & dot_s.in_valid;
  // Vector ends on an explicit last or when the beat count reaches MAX_LEN.
  assign beat_end_c = dot_s.in_last | ((cnt_q + CNT_W'(1)) == LEN_MAX);
  // Extra MSB captures the carry out of the accumulator.
  assign sum_c      = {1'b0, acc_q} + SUM_W'(s1_q.prod);

  // Next-state, pipeline and accumulator update.
  always_comb begin
    state_d     = state_q;
    s1_d        = '0;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    s1_d.valid = accept_c;
    s1_d.last  = accept_c & beat_end_c;
    s1_d.prod  = prod_c;

    if (accept_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (s1_q.valid) begin
      if (sum_c[ACC_W]) begin
        ovf_d = 1'b1;
      end
`ifdef APPROX_DOT_SAT_EN
      // Once clamped, stay at full scale for the rest of the vector.
      if (ovf_q || sum_c[ACC_W]) begin
        acc_d = '1;
      end else begin
        acc_d = sum_c[ACC_W-1:0];
      end
`else
      acc_d = sum_c[ACC_W-1:0];
`endif
    end

    case (state_q)
      S_ACCUM: begin
        if (accept_c && beat_end_c) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The final add lands this cycle, so the result is ready next cycle.
        if (s1_q.valid && s1_q.last) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (dot_s.out_ready) begin
          state_d     = S_ACCUM;
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
        end
      end
      default: begin
        state_d     = S_ACCUM;
        out_valid_d = 1'b0;
      end
    endcase

    in_ready_d = (state_d == S_ACCUM);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ACCUM;
      s1_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign dot_s.in_ready  = in_ready_q;
  assign dot_s.out_valid = out_valid_q;
  assign dot_s.out_sum   = acc_q;
  assign dot_s.out_count = cnt_q;
  assign dot_s.out_ovf   = ovf_q;

endmodule

// File: tb/tb_approx_dot_acc.sv
// Self-checking bench for approx_dot_acc (ACC_W=8, MAX_LEN=4 so overflow and
// the forced-last boundary are both reachable with short vectors).
module tb_approx_dot_acc;
  import approx_dot_pkg::*;

  localparam int unsigned ACC_W   = 8;
  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);
  localparam int          ACC_MAX = (1 << ACC_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  approx_dot_acc_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  approx_dot_acc #(.ACC_W(ACC_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .dot_s (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // 2x2 block values m(a,b), indexed a*4+b, tabulated from the block rule.
  int mtab [16] = '{0, 0, 0, 0,
                    0, 0, 2, 2,
                    0, 3, 4, 7,
                    0, 3, 6, 7};

  int qa[$];
  int qb[$];
  int exp_sum, exp_cnt, exp_ovf;

  function automatic int ref_prod(int x, int y);
    return mtab[(x % 4) * 4 + (y % 4)]
         + mtab[(x % 4) * 4 + (y / 4)] * 4
         + mtab[(x / 4) * 4 + (y % 4)] * 4
         + mtab[(x / 4) * 4 + (y / 4)] * 16;
  endfunction

  function automatic int ref_sum(int raw);
`ifdef APPROX_DOT_SAT_EN
    return (raw > ACC_MAX) ? ACC_MAX : raw;
`else
    return raw % (ACC_MAX + 1);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Push the queued beats, then check drain timing and the result.
  task automatic drive_vec(input bit use_last, input bit hold_next);
    int raw = 0;
    int n   = qa.size();
    for (int i = 0; i < n; i++) begin
      raw += ref_prod(qa[i], qb[i]);
      @(negedge clk);
      chk("in_ready_beat", 32'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_a     = 4'(qa[i]);
      bus.in_b     = 4'(qb[i]);
      bus.in_last  = use_last && (i == n - 1);
      @(posedge clk);
    end
    exp_cnt = n;
    exp_ovf = (raw > ACC_MAX) ? 1 : 0;
    exp_sum = ref_sum(raw);
    @(negedge clk);
    if (hold_next) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 4'd2;
      bus.in_b     = 4'd2;
      bus.in_last  = 1'b1;
    end else begin
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
    chk("in_ready_t1", 32'(bus.in_ready), 0);
    chk("out_valid_t1", 32'(bus.out_valid), 0);
    @(negedge clk);
    chk("out_valid_t2", 32'(bus.out_valid), 1);
    chk("out_sum", 32'(bus.out_sum), 32'(exp_sum));
    chk("out_count", 32'(bus.out_count), 32'(exp_cnt));
    chk("out_ovf", 32'(bus.out_ovf), 32'(exp_ovf));
    qa.delete();
    qb.delete();
  endtask

  // Optionally back-pressure the result, then complete the handshake.
  task automatic finish_result(input int hold);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      chk("bp_out_sum", 32'(bus.out_sum), 32'(exp_sum));
      chk("bp_out_count", 32'(bus.out_count), 32'(exp_cnt));
      chk("bp_in_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("hs_out_valid", 32'(bus.out_valid), 0);
    chk("hs_in_ready", 32'(bus.in_ready), 1);
  endtask

  task automatic one_vec(input int a0, input int b0);
    qa.push_back(a0);
    qb.push_back(b0);
    bus.out_ready = 1'b1;
    drive_vec(1'b1, 1'b0);
    finish_result(0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = 4'd0;
    bus.in_b      = 4'd0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        chk("pkg_mul4", 32'(approx_mul4(4'(x), 4'(y))), 32'(ref_prod(x, y)));

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_sum", 32'(bus.out_sum), 0);
    chk("rst_out_count", 32'(bus.out_count), 0);
    chk("rst_out_ovf", 32'(bus.out_ovf), 0);

    // Basic three-beat vector.
    qa = '{3, 2, 8};
    qb = '{3, 3, 8};
    bus.out_ready = 1'b1;
    drive_vec(1'b1, 1'b0);
    finish_result(0);

    // Single-beat exactness spots.
    one_vec(1, 1);
    one_vec(2, 2);
    one_vec(4, 4);
    one_vec(15, 15);

    // Back-pressure for 5 cycles.
    qa = '{5, 9};
    qb = '{7, 6};
    bus.out_ready = 1'b0;
    drive_vec(1'b1, 1'b0);
    finish_result(5);

    // Overflow.
    qa = '{15, 15};
    qb = '{15, 15};
    bus.out_ready = 1'b1;
    drive_vec(1'b1, 1'b0);
    finish_result(0);

    // MAX_LEN forced last; the next beat waits for the handshake.
    qa = '{2, 2, 2, 2};
    qb = '{2, 2, 2, 2};
    bus.out_ready = 1'b0;
    drive_vec(1'b0, 1'b1);
    finish_result(3);
    @(posedge clk);
    exp_cnt = 1;
    exp_sum = 4;
    exp_ovf = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("held_in_ready_t1", 32'(bus.in_ready), 0);
    @(negedge clk);
    chk("held_out_valid", 32'(bus.out_valid), 1);
    chk("held_out_sum", 32'(bus.out_sum), 32'(exp_sum));
    chk("held_out_count", 32'(bus.out_count), 32'(exp_cnt));
    finish_result(0);

    // Reset mid-vector.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = 4'd3;
      bus.in_b     = 4'd3;
      bus.in_last  = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
      chk("mid_rst_out_count", 32'(bus.out_count), 0);
      chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
    end
    one_vec(2, 2);

    // Randomized vectors.
    for (int v = 0; v < 24; v++) begin
      int len  = $urandom_range(1, MAX_LEN);
      int hold = $urandom_range(0, 3);
      bit ul   = (len < MAX_LEN) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        qa.push_back($urandom_range(0, 15));
        qb.push_back($urandom_range(0, 15));
      end
      bus.out_ready = (hold == 0);
      drive_vec(ul, 1'b0);
      finish_result(hold);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
